// File: rtl/eros_ext_obi_responder_if.sv
`default_nettype none
// eros_ext_obi_responder_if: OBI request/response bundle between initiator and responder.
interface eros_ext_obi_responder_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface
`default_nettype wire

// File: rtl/eros_ext_obi_responder.sv
`default_nettype none
// eros_ext_obi_responder: fixed-latency, in-order OBI scratch-RAM target (rev 1.0).
// Optional macro EROS_EXT_RESP_STALL_EN enables LFSR-driven grant back-pressure.
module eros_ext_obi_responder #(
  parameter int unsigned DEPTH_WORDS     = 256,
  parameter logic [31:0] BASE_ADDR       = 32'h2000_0000,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  wire logic                 clk_i,
  input  wire logic                 rst_ni,
  eros_ext_obi_responder_if.slave   slave,
  output logic [CNT_W-1:0]          outstanding_o,
  output logic                      oob_access_o
);

  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] REGION_END = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [31:0] OOB_DATA   = 32'hBADC_AB1E;

  generate
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("eros_ext_obi_responder: LATENCY must be within 1..4");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > LATENCY + 1) begin : g_bad_outstanding
      $error("eros_ext_obi_responder: MAX_OUTSTANDING must be within 1..LATENCY+1");
    end
  endgenerate

  logic [31:0]        mem_q [DEPTH_WORDS];
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [31:0]        dat_q [LATENCY];
  logic [31:0]        dat_d [LATENCY];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               oob_q, oob_d;

  logic               w_stall;
  logic               w_gnt;
  logic               w_in_range;
  logic               w_rvalid;
  logic [31:0]        w_offset;
  logic [IDX_W-1:0]   w_idx;
  logic [31:0]        w_rsp_data;

`ifdef EROS_EXT_RESP_STALL_EN
  // x^16+x^14+x^13+x^11+1 in right-shift Fibonacci form: taps at bits 0,2,3,5.
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign w_stall = (lfsr_q[1:0] == 2'b00);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign w_stall = 1'b0;
`endif

  assign w_in_range = ({1'b0, slave.addr} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, slave.addr} <  REGION_END);
  assign w_offset   = slave.addr - BASE_ADDR;
  assign w_idx      = IDX_W'(w_offset >> 2);
  assign w_gnt      = slave.req && (cnt_q < CNT_W'(MAX_OUTSTANDING)) && !w_stall && rst_ni;
  assign w_rvalid   = vld_q[LATENCY-1];

  // Read data is the pre-edge word, so a write granted on the previous edge is already visible.
  assign w_rsp_data = slave.we   ? 32'h0 :
                      w_in_range ? mem_q[w_idx] : OOB_DATA;

  always_ff @(posedge clk_i) begin
    if (w_gnt && slave.we && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (slave.be[b]) begin
          mem_q[w_idx][8*b +: 8] <= slave.wdata[8*b +: 8];
        end
      end
    end
  end

  // Final stage only loads when a response arrives, so rdata holds between responses.
  always_comb begin
    vld_d    = '0;
    dat_d    = dat_q;
    vld_d[0] = w_gnt;
    if (w_gnt) begin
      dat_d[0] = w_rsp_data;
    end
    for (int s = 1; s < LATENCY; s++) begin
      vld_d[s] = vld_q[s-1];
      if (vld_q[s-1]) begin
        dat_d[s] = dat_q[s-1];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({w_gnt, w_rvalid})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    oob_d = w_gnt && !w_in_range;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      dat_q <= '{default: '0};
      cnt_q <= '0;
      oob_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
      oob_q <= oob_d;
    end
  end

  assign slave.gnt     = w_gnt;
  assign slave.rvalid  = w_rvalid;
  assign slave.rdata   = dat_q[LATENCY-1];
  assign outstanding_o = cnt_q;
  assign oob_access_o  = oob_q;

endmodule
`default_nettype wire

// File: tb/tb_eros_ext_obi_responder.sv
`default_nettype none
// tb_eros_ext_obi_responder: directed + random stimulus against a queue-based reference model.
module tb_eros_ext_obi_responder;
  localparam int          DEPTH = 16;
  localparam int          LAT   = 3;
  localparam int          MAXO  = 2;
  localparam logic [31:0] BASE  = 32'h2000_0000;

  typedef struct { int cyc; logic [31:0] data; bit known; } exp_t;
  typedef struct { int cyc; logic [31:0] data; } rsp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] outstanding;
  logic       oob;

  eros_ext_obi_responder_if bus();

  eros_ext_obi_responder #(
    .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .slave(bus),
    .outstanding_o(outstanding), .oob_access_o(oob)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit last_hs = 1'b0;
  int req_elig = 0;
  int req_supp = 0;

  logic [31:0] mdl_mem [DEPTH];
  bit          mdl_known [DEPTH];
  int          mdl_cnt = 0;
  bit          mdl_oob = 1'b0;
  exp_t        exp_q[$];
  rsp_t        rsp_log[$];
  int          gnt_log[$];
  int          oob_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: sampled mid-cycle, then advanced to represent the coming edge.
  always @(negedge clk) begin
    bit exp_gnt, exp_rv, hs, inr;
    longint a;
    int idx;
    logic [31:0] d;
    exp_rv  = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    exp_gnt = rst_n && bus.req && (mdl_cnt < MAXO);
`ifdef EROS_EXT_RESP_STALL_EN
    if (bus.gnt && !exp_gnt) chk("gnt_illegal", 32'(bus.gnt), 32'(exp_gnt));
    if (exp_gnt) begin
      req_elig++;
      if (!bus.gnt) req_supp++;
    end
    hs = bus.gnt && exp_gnt;
`else
    chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
    hs = exp_gnt;
`endif
    chk("rvalid", 32'(bus.rvalid), 32'(exp_rv));
    if (exp_rv && exp_q[0].known) chk("rdata", bus.rdata, exp_q[0].data);
    chk("outstanding", 32'(outstanding), 32'(mdl_cnt));
    chk("oob_access", 32'(oob), 32'(mdl_oob));
    if (bus.rvalid) rsp_log.push_back('{cyc, bus.rdata});
    if (oob) oob_log.push_back(cyc);
    if (hs) gnt_log.push_back(cyc);
    last_hs = hs;
    if (!rst_n) begin
      exp_q.delete();
      mdl_cnt = 0;
      mdl_oob = 1'b0;
    end else begin
      if (exp_rv) begin
        void'(exp_q.pop_front());
        mdl_cnt--;
      end
      mdl_oob = 1'b0;
      if (hs) begin
        a   = longint'(bus.addr);
        inr = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
        idx = inr ? int'((a - longint'(BASE)) / 4) : 0;
        if (bus.we) begin
          if (inr) begin
            for (int b = 0; b < 4; b++)
              if (bus.be[b]) mdl_mem[idx][8*b +: 8] = bus.wdata[8*b +: 8];
            if (bus.be == 4'hF) mdl_known[idx] = 1'b1;
          end
          exp_q.push_back('{cyc + LAT, 32'h0, 1'b1});
        end else if (inr) begin
          exp_q.push_back('{cyc + LAT, mdl_mem[idx], mdl_known[idx]});
        end else begin
          exp_q.push_back('{cyc + LAT, 32'hBADC_AB1E, 1'b1});
        end
        mdl_cnt++;
        mdl_oob = !inr;
      end
    end
    cyc++;
  end

  task automatic hold_gnt();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk); #1;
      if (last_hs) return;
    end
    checks++;
    failures++;
    $display("FAIL gnt_timeout @cycle %0d: got no grant required grant within 200 cycles", cyc);
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.be = be; bus.wdata = wd;
  endtask

  task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] be,
                     input logic [31:0] wd, output int ri, output int gc);
    @(posedge clk); #1;
    ri = rsp_log.size() + exp_q.size();
    drive(w, a, be, wd);
    hold_gnt();
    gc = (gnt_log.size() > 0) ? gnt_log[gnt_log.size()-1] : -1;
    @(posedge clk); #1;
    bus.req = 1'b0;
  endtask

  task automatic get_rsp(input int idx, output logic [31:0] d, output int c);
    for (int n = 0; n < 100; n++) begin
      if (rsp_log.size() > idx) begin
        d = rsp_log[idx].data;
        c = rsp_log[idx].cyc;
        return;
      end
      @(negedge clk); #1;
    end
    d = '0;
    c = -1;
    checks++;
    failures++;
    $display("FAIL rsp_timeout @cycle %0d: got no response required response #%0d", cyc, idx);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100; n++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk); #1;
    end
    checks++;
    failures++;
    $display("FAIL idle_timeout @cycle %0d: got %0d pending required 0", cyc, exp_q.size());
  endtask

  task automatic rand_txn();
    int k = $urandom_range(0, DEPTH - 1);
    bus.req   = 1'b1;
    bus.we    = 1'($urandom_range(0, 1));
    bus.be    = 4'($urandom);
    bus.wdata = $urandom;
    if ($urandom_range(0, 9) == 0)
      bus.addr = ($urandom_range(0, 1) == 0) ? BASE + 32'(4 * DEPTH) + 32'(4 * k) : BASE - 32'd4;
    else
      bus.addr = BASE + 32'(4 * k);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ri, gc, rc, g0, r0, t0, o0, issued;
    logic [31:0] rd;
    int exp_g[4];
    int exp_r[4];
    bit drained;
    exp_g = '{0, 1, 4, 5};
    exp_r = '{3, 4, 7, 8};
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.be = '0; bus.wdata = '0;
    for (int i = 0; i < DEPTH; i++) mdl_known[i] = 1'b0;

    // Reset: request held high must not be granted.
    repeat (2) @(posedge clk);
    #1 drive(1'b0, BASE, 4'hF, 32'h0);
    @(negedge clk); #1;
    chk("reset_gnt", 32'(bus.gnt), 32'h0);
    chk("reset_rvalid", 32'(bus.rvalid), 32'h0);
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_outstanding", 32'(outstanding), 32'h0);
    chk("reset_oob", 32'(oob), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req = 1'b0;

    for (int k = 0; k < DEPTH; k++) txn(1'b1, BASE + 32'(4 * k), 4'hF, 32'h1000_0000 + 32'(k), ri, gc);

    wait_idle();
    txn(1'b1, BASE + 32'd8, 4'hF, 32'hDEAD_BEEF, ri, gc);
    get_rsp(ri, rd, rc);
    chk("wr_rsp_rdata", rd, 32'h0);
    chk("wr_rsp_latency", 32'(rc - gc), 32'(LAT));
    txn(1'b0, BASE + 32'd8, 4'hF, 32'h0, ri, gc);
    get_rsp(ri, rd, rc);
    chk("rd_full_word", rd, 32'hDEAD_BEEF);
    txn(1'b1, BASE + 32'd8, 4'b0010, 32'h0000_5500, ri, gc);
    txn(1'b0, BASE + 32'd8, 4'hF, 32'h0, ri, gc);
    get_rsp(ri, rd, rc);
    chk("rd_partial", rd, 32'hDEAD_55EF);
    txn(1'b1, BASE + 32'd8, 4'b0000, 32'hFFFF_FFFF, ri, gc);
    txn(1'b0, BASE + 32'd8, 4'hF, 32'h0, ri, gc);
    get_rsp(ri, rd, rc);
    chk("rd_after_be0", rd, 32'hDEAD_55EF);

    o0 = oob_log.size();
    txn(1'b0, BASE + 32'(4 * DEPTH), 4'hF, 32'h0, ri, gc);
    get_rsp(ri, rd, rc);
    chk("oob_rdata", rd, 32'hBADC_AB1E);
    chk("oob_pulse_count", 32'(oob_log.size() - o0), 32'd1);
    chk("oob_pulse_cycle", 32'(oob_log[oob_log.size()-1]), 32'(gc + 1));
    txn(1'b1, BASE + 32'(4 * DEPTH), 4'hF, 32'hFFFF_FFFF, ri, gc);
    txn(1'b0, BASE, 4'hF, 32'h0, ri, gc);
    get_rsp(ri, rd, rc);
    chk("oob_write_dropped", rd, 32'h1000_0000);

    // Read-after-write in consecutive grants.
    wait_idle();
    @(posedge clk); #1;
    ri = rsp_log.size() + exp_q.size();
    drive(1'b1, BASE + 32'd12, 4'hF, 32'h1234_5678);
    hold_gnt();
    @(posedge clk); #1;
    bus.we = 1'b0;
    hold_gnt();
    @(posedge clk); #1;
    bus.req = 1'b0;
    get_rsp(ri + 1, rd, rc);
    chk("raw_consecutive", rd, 32'h1234_5678);

    // Four reads with req held: the outstanding cap throttles the grants.
    wait_idle();
    @(posedge clk); #1;
    t0 = cyc;
    g0 = gnt_log.size();
    r0 = rsp_log.size();
    drive(1'b0, BASE + 32'd16, 4'hF, 32'h0);
    for (int k = 0; k < 4; k++) begin
      hold_gnt();
      @(posedge clk); #1;
      if (k < 3) bus.addr = BASE + 32'(4 * (5 + k));
      else bus.req = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      get_rsp(r0 + k, rd, rc);
      chk("burst_rdata", rd, 32'h1000_0004 + 32'(k));
`ifndef EROS_EXT_RESP_STALL_EN
      chk("burst_gnt_cycle", 32'(gnt_log[g0 + k] - t0), 32'(exp_g[k]));
      chk("burst_rvalid_cycle", 32'(rc - t0), 32'(exp_r[k]));
`endif
    end

    // Reset with a write and a read in flight.
    wait_idle();
    @(posedge clk); #1;
    drive(1'b1, BASE + 32'd36, 4'hF, 32'hCAFE_F00D);
    hold_gnt();
    @(posedge clk); #1;
    bus.we = 1'b0;
    hold_gnt();
    @(posedge clk); #1;
    bus.req = 1'b0;
    rst_n = 1'b0;
    r0 = rsp_log.size();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    #1;
    chk("no_rvalid_after_reset", 32'(rsp_log.size() - r0), 32'h0);
    chk("outstanding_after_reset", 32'(outstanding), 32'h0);
    txn(1'b0, BASE + 32'd36, 4'hF, 32'h0, ri, gc);
    get_rsp(ri, rd, rc);
    chk("write_kept_over_reset", rd, 32'hCAFE_F00D);

    // Random traffic, back-to-back where the driver allows.
    wait_idle();
    issued = 0;
    while (issued < 600) begin
      @(posedge clk); #1;
      if (bus.req && !last_hs) continue;
      if ($urandom_range(0, 4) == 0) bus.req = 1'b0;
      else begin
        rand_txn();
        issued++;
      end
    end
    drained = 1'b0;
    for (int n = 0; n < 200 && !drained; n++) begin
      @(posedge clk); #1;
      if (!(bus.req && !last_hs)) drained = 1'b1;
    end
    if (!drained) begin
      checks++;
      failures++;
      $display("FAIL random_drain @cycle %0d: got req still pending required grant", cyc);
    end
    bus.req = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

`ifdef EROS_EXT_RESP_STALL_EN
    checks++;
    if (req_elig == 0 || req_supp * 100 < req_elig * 10 || req_supp * 100 > req_elig * 40) begin
      failures++;
      $display("FAIL stall_ratio: got %0d of %0d suppressed required about 25%%", req_supp, req_elig);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
